// File: rtl/config_loader.sv
// Master of the serial configuration chain: serialises bitstream words onto config_in/config_en,
// then optionally rotates the chain once through itself and compares CRCs to confirm the load.
module config_loader #(
    parameter int CHAIN_LEN = 16,
    parameter int WORD_W    = 8
) (
    input  logic              config_clk,
    input  logic              config_rst_n,
    input  logic              start,
    input  logic              verify_en,
    input  logic [WORD_W-1:0] word_in,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              chain_di,
    output logic              chain_en,
    input  logic              chain_do,
    output logic              busy,
    output logic              done,
    output logic              crc_ok,
    output logic              err
);

    localparam int BW = $clog2(CHAIN_LEN + 1);
    localparam int SW = $clog2(WORD_W + 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(CHAIN_LEN);
    localparam logic [SW-1:0] LAST_SLOT = SW'(WORD_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SHIFT,
        S_VERIFY,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic              verify_q, verify_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [SW-1:0]     slot_q, slot_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [BW-1:0]     bit_inc;
    logic [15:0]       crc_load_q, crc_load_d;
    logic [15:0]       crc_ver_q, crc_ver_d;
    logic              crc_ok_q, crc_ok_d;
    logic              err_q, err_d;

    function automatic logic [15:0] crcStep(input logic [15:0] crc, input logic b);
        logic fb;
        fb = crc[15] ^ b;
        return {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    assign bit_inc = bit_q + 1'b1;
    assign crc_ok  = crc_ok_q;
    assign err     = err_q;

    always_ff @(posedge config_clk or negedge config_rst_n) begin
        if (!config_rst_n) begin
            state_q    <= S_IDLE;
            verify_q   <= 1'b0;
            shreg_q    <= '0;
            slot_q     <= '0;
            bit_q      <= '0;
            crc_load_q <= 16'hFFFF;
            crc_ver_q  <= 16'hFFFF;
            crc_ok_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            verify_q   <= verify_d;
            shreg_q    <= shreg_d;
            slot_q     <= slot_d;
            bit_q      <= bit_d;
            crc_load_q <= crc_load_d;
            crc_ver_q  <= crc_ver_d;
            crc_ok_q   <= crc_ok_d;
            err_q      <= err_d;
        end
    end

    // bit_q counts load bits in SHIFT and is reused as the rotation counter in VERIFY
    always_comb begin
        state_d    = state_q;
        verify_d   = verify_q;
        shreg_d    = shreg_q;
        slot_d     = slot_q;
        bit_d      = bit_q;
        crc_load_d = crc_load_q;
        crc_ver_d  = crc_ver_q;
        crc_ok_d   = crc_ok_q;
        err_d      = err_q;
        word_ready = 1'b0;
        chain_en   = 1'b0;
        chain_di   = 1'b0;
        done       = 1'b0;
        busy       = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    verify_d   = verify_en;
                    err_d      = 1'b0;
                    crc_ok_d   = 1'b0;
                    bit_d      = '0;
                    crc_load_d = 16'hFFFF;
                    crc_ver_d  = 16'hFFFF;
                    state_d    = S_FETCH;
                end
            end
            S_FETCH: begin
                word_ready = 1'b1;
                if (word_valid) begin
                    shreg_d = word_in;
                    slot_d  = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                chain_en   = 1'b1;
                chain_di   = shreg_q[0];
                shreg_d    = shreg_q >> 1;
                slot_d     = slot_q + 1'b1;
                bit_d      = bit_inc;
                crc_load_d = crcStep(crc_load_q, shreg_q[0]);
                if (bit_inc == LAST_BIT) begin
                    bit_d   = '0;
                    state_d = verify_q ? S_VERIFY : S_DONE;
                end else if (slot_q == LAST_SLOT) begin
                    state_d = S_FETCH;
                end
            end
            S_VERIFY: begin
                chain_en  = 1'b1;
                chain_di  = chain_do;
                crc_ver_d = crcStep(crc_ver_q, chain_do);
                bit_d     = bit_inc;
                if (bit_inc == LAST_BIT) begin
                    crc_ok_d = (crc_ver_d == crc_load_q);
                    err_d    = (crc_ver_d != crc_load_q);
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_config_loader.sv
// Bench for config_loader: drives words with random stalls and faults into a behavioural chain
// model and compares chain traffic, CRC verdicts and handshake counts against a reference.
module tb_config_loader;

    localparam int LEN = 20;
    localparam int W   = 8;
    localparam int NW  = (LEN + W - 1) / W;

    logic         config_clk   = 1'b0;
    logic         config_rst_n = 1'b0;
    logic         start        = 1'b0;
    logic         verify_en    = 1'b0;
    logic [W-1:0] word_in      = '0;
    logic         word_valid   = 1'b0;
    logic         word_ready;
    logic         chain_di;
    logic         chain_en;
    logic         chain_do;
    logic         busy;
    logic         done;
    logic         crc_ok;
    logic         err;

    logic [LEN-1:0] chainQ = '0;
    int             enCount = 0;
    int             hsCount = 0;
    int             doneCount = 0;
    bit             diQ[$];
    bit             faultArm = 1'b0;
    int             faultBase = 0;
    logic [W-1:0]   words[NW];
    int             testCount = 0;
    int             failCount = 0;

    config_loader #(.CHAIN_LEN(LEN), .WORD_W(W)) dut (
        .config_clk  (config_clk),
        .config_rst_n(config_rst_n),
        .start       (start),
        .verify_en   (verify_en),
        .word_in     (word_in),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .chain_di    (chain_di),
        .chain_en    (chain_en),
        .chain_do    (chain_do),
        .busy        (busy),
        .done        (done),
        .crc_ok      (crc_ok),
        .err         (err)
    );

    always #5 config_clk = ~config_clk;

    assign chain_do = chainQ[LEN-1];

    // Behavioural fabric chain: config_in enters stage 0, config_out is the last stage
    always @(posedge config_clk) begin
        logic [LEN-1:0] nxt;
        if (chain_en) begin
            nxt = {chainQ[LEN-2:0], chain_di};
            if (faultArm && (enCount - faultBase == LEN - 1)) nxt[7] = ~nxt[7];
            chainQ <= nxt;
            enCount <= enCount + 1;
            diQ.push_back(chain_di);
        end
        if (word_valid && word_ready) hsCount <= hsCount + 1;
        if (done) doneCount <= doneCount + 1;
    end

    function automatic logic [15:0] crcOf(input bit bits[$]);
        logic [15:0] c;
        bit fb;
        c = 16'hFFFF;
        foreach (bits[i]) begin
            fb = c[15] ^ bits[i];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, ".word_ready"}, 32'(word_ready), 0);
        checkOutput({tag, ".chain_en"}, 32'(chain_en), 0);
        checkOutput({tag, ".chain_di"}, 32'(chain_di), 0);
        checkOutput({tag, ".busy"}, 32'(busy), 0);
        checkOutput({tag, ".done"}, 32'(done), 0);
        checkOutput({tag, ".crc_ok"}, 32'(crc_ok), 0);
        checkOutput({tag, ".err"}, 32'(err), 0);
    endtask

    task automatic randomWords();
        for (int i = 0; i < NW; i++) words[i] = W'($urandom);
    endtask

    // One complete load; abortAt > 0 pulls reset after that many chain pulses instead of finishing
    task automatic applyStimulus(input bit doVerify, input bit fault, input int stallLen,
                                 input bit midStart, input int abortAt);
        int enBase, hsBase, doneBase, qBase, cnt, mism;
        bit expBits[$];
        bit preBits[$];
        logic [LEN-1:0] expPat, flipMask, prePat;
        bit expOk;

        flipMask = '0;
        if (fault) flipMask[7] = 1'b1;
        for (int i = 0; i < LEN; i++) begin
            expBits.push_back(words[i / W][i % W]);
            expPat[LEN-1-i] = words[i / W][i % W];
        end
        prePat = expPat ^ flipMask;
        for (int i = 0; i < LEN; i++) preBits.push_back(prePat[LEN-1-i]);
        expOk = doVerify && (crcOf(expBits) == crcOf(preBits));

        @(negedge config_clk);
        enBase    = enCount;
        hsBase    = hsCount;
        doneBase  = doneCount;
        qBase     = diQ.size();
        faultBase = enCount;
        faultArm  = fault;
        start     = 1'b1;
        verify_en = doVerify;
        @(negedge config_clk);
        start     = 1'b0;
        verify_en = 1'($urandom_range(0, 1));
        checkOutput("busyAfterStart", 32'(busy), 1);
        checkOutput("errClearedByStart", 32'(err), 0);
        checkOutput("crcOkClearedByStart", 32'(crc_ok), 0);

        for (int w = 0; w < NW; w++) begin
            cnt = 0;
            while (!word_ready && cnt < 50) begin
                @(negedge config_clk);
                cnt++;
            end
            if (!word_ready) begin
                checkOutput("readyTimeout", 0, 1);
                faultArm = 1'b0;
                return;
            end
            if (w == 1 && stallLen > 0) begin
                repeat (stallLen) begin
                    checkOutput("stallReady", 32'(word_ready), 1);
                    checkOutput("stallNoShift", 32'(chain_en), 0);
                    @(negedge config_clk);
                end
            end
            word_valid = 1'b1;
            word_in    = words[w];
            @(negedge config_clk);
            word_valid = 1'b0;
            word_in    = W'($urandom);
            if (midStart && w == 1) begin
                checkOutput("midStartInShift", 32'(chain_en), 1);
                start = 1'b1;
                @(negedge config_clk);
                start = 1'b0;
            end
            if (abortAt > 0 && w == 1) begin
                cnt = 0;
                while ((enCount - enBase) < abortAt && cnt < 50) begin
                    @(negedge config_clk);
                    cnt++;
                end
                checkOutput("abortPoint", enCount - enBase, abortAt);
                config_rst_n = 1'b0;
                #1;
                checkIdleOutputs("midReset");
                @(negedge config_clk);
                config_rst_n = 1'b1;
                faultArm = 1'b0;
                return;
            end
        end

        cnt = 0;
        while (!done && cnt < 100) begin
            @(negedge config_clk);
            cnt++;
        end
        checkOutput("donePulse", 32'(done), 1);
        if (!done) begin
            faultArm = 1'b0;
            return;
        end
        checkOutput("crcOkAtDone", 32'(crc_ok), 32'(expOk));
        checkOutput("errAtDone", 32'(err), 32'(doVerify && !expOk));
        @(negedge config_clk);
        checkOutput("busyAfterDone", 32'(busy), 0);
        checkOutput("doneSingleCycle", 32'(done), 0);
        repeat (3) @(negedge config_clk);
        checkOutput("enPulses", enCount - enBase, doVerify ? 2 * LEN : LEN);
        checkOutput("handshakes", hsCount - hsBase, NW);
        checkOutput("doneCount", doneCount - doneBase, 1);
        mism = 0;
        for (int i = 0; i < LEN; i++) begin
            if (qBase + i >= diQ.size() || diQ[qBase + i] != expBits[i]) mism++;
        end
        checkOutput("diSequence", mism, 0);
        checkOutput("chainContents", 32'(chainQ), 32'(prePat));
        faultArm = 1'b0;
    endtask

    initial begin
        config_rst_n = 1'b0;
        #1;
        checkIdleOutputs("reset");
        repeat (2) @(negedge config_clk);
        config_rst_n = 1'b1;

        words[0] = 8'hA5;
        words[1] = 8'h3C;
        words[2] = 8'h0F;
        applyStimulus(1'b0, 1'b0, 0, 1'b0, 0);
        applyStimulus(1'b1, 1'b0, 0, 1'b0, 0);
        applyStimulus(1'b1, 1'b1, 0, 1'b0, 0);
        repeat (4) @(negedge config_clk);
        checkOutput("errSticky", 32'(err), 1);
        checkOutput("crcOkHeld", 32'(crc_ok), 0);

        randomWords();
        applyStimulus(1'b0, 1'b0, 5, 1'b0, 0);
        randomWords();
        applyStimulus(1'b1, 1'b0, 0, 1'b0, 11);
        randomWords();
        applyStimulus(1'b1, 1'b0, 0, 1'b0, 0);
        randomWords();
        applyStimulus(1'b0, 1'b0, 0, 1'b1, 0);

        for (int r = 0; r < 6; r++) begin
            randomWords();
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          $urandom_range(0, 4), 1'b0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
